// File: rtl/qspline_mul_pkg.sv
// rtl/qspline_mul_pkg.sv - shared widths and id-width helper for the multiplier arbiter
package qspline_mul_pkg;

  localparam int DIN_W       = 16;
  localparam int DOUT_W      = 2 * DIN_W;
  localparam int NUM_REQ_DEF = 4;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qspline_mul_arbiter_if.sv
// rtl/qspline_mul_arbiter_if.sv - requester and result handshake bundle
interface qspline_mul_arbiter_if
  import qspline_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DIN_W   = qspline_mul_pkg::DIN_W,
  parameter int DOUT_W  = 2 * DIN_W
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*DIN_W-1:0] req_a;
  logic [NUM_REQ*DIN_W-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [DOUT_W-1:0]        rsp_data;

  // Requesters and result consumer
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // The arbiter
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/qspline_mul_core.sv
// rtl/qspline_mul_core.sv - combinational full-precision signed multiplier
module qspline_mul_core
  import qspline_mul_pkg::*;
#(
  parameter int A_W = DIN_W,
  parameter int P_W = 2 * A_W
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [A_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  // Both operands signed, result sized to the full product: no rounding or wrap.
  assign p = a * b;

endmodule

// File: rtl/qspline_mul_arbiter.sv
// rtl/qspline_mul_arbiter.sv - round-robin share of one multiplier with a 1-deep result register
module qspline_mul_arbiter
  import qspline_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DIN_W   = qspline_mul_pkg::DIN_W,
  parameter int DOUT_W  = 2 * DIN_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  qspline_mul_arbiter_if.slave  bus
);

  localparam int ID_W = id_w(NUM_REQ);

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [DOUT_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic              slot_free;
  logic              accept;

  logic signed [DIN_W-1:0]  mul_a;
  logic signed [DIN_W-1:0]  mul_b;
  logic signed [DOUT_W-1:0] mul_p;

  // Round-robin winner: smallest circular distance past last_grant among valid requesters.
  always_comb begin
    int best_d;
    int d;
    win_found = 1'b0;
    win_idx   = '0;
    best_d    = NUM_REQ;
    d         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(last_grant_q) - 1;
      if (d < 0) d = d + NUM_REQ;
      if (bus.req_valid[i] && (d < best_d)) begin
        best_d    = d;
        win_idx   = ID_W'(i);
        win_found = 1'b1;
      end
    end
  end

  // Slot is free when empty or being popped; reset blocks every grant.
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign accept    = win_found && slot_free && !ap_rst;

  // Grant one-hot and steer only the winner's operands into the multiplier.
  always_comb begin
    bus.req_ready = '0;
    mul_a         = '0;
    mul_b         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        bus.req_ready[i] = accept;
        mul_a            = bus.req_a[i*DIN_W +: DIN_W];
        mul_b            = bus.req_b[i*DIN_W +: DIN_W];
      end
    end
  end

  qspline_mul_core #(
    .A_W (DIN_W),
    .P_W (DOUT_W)
  ) u_core (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Result register next state: push replaces, lone pop empties, otherwise hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = win_idx;
      rsp_data_d   = mul_p;
      last_grant_d = win_idx;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_qspline_mul_arbiter.sv
// tb/tb_qspline_mul_arbiter.sv - self-checking bench for the multiplier arbiter
module tb_qspline_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int DW = 32;
  localparam int IW = 2;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;

  always #5 ap_clk = ~ap_clk;

  qspline_mul_arbiter_if #(.NUM_REQ(N), .DIN_W(W), .DOUT_W(DW)) bus ();

  qspline_mul_arbiter #(.NUM_REQ(N), .DIN_W(W), .DOUT_W(DW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus shadow
  logic [N-1:0]         v;
  logic signed [W-1:0]  op_a [N];
  logic signed [W-1:0]  op_b [N];
  logic                 rr;
  logic [N-1:0]         s_ready;

  // Reference model: one result slot plus the last granted requester
  bit                m_valid;
  int                m_id;
  logic [DW-1:0]     m_data;
  int                m_last;

  typedef struct {
    int                  id;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic [N-1:0]        exp_ready;
    logic [DW-1:0]       exp_p;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
    end
    bus.req_valid = v;
    bus.rsp_ready = rr;
  endtask

  // Winner from the rules: slot must be free, search begins one past last grant.
  function automatic int m_winner();
    if (m_valid && !rr) return -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] m_mul(input int i);
    longint pa;
    longint pb;
    pa = longint'(op_a[i]);
    pb = longint'(op_b[i]);
    return DW'(pa * pb);
  endfunction

  function automatic logic signed [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'sh8000;
      1:       return 16'sh7fff;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: called at posedge+1 with inputs settled; checks mid-cycle, then advances the model.
  task automatic step(output int g);
    logic [DW-1:0] p;
    #4;
    g = m_winner();
    p = (g >= 0) ? m_mul(g) : '0;
    s_ready = bus.req_ready;
    chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
    end
    @(posedge ap_clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
      m_data  = p;
      m_last  = g;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    v      = '1;
    rr     = 1'b1;
    drive();
    #2;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_data", 64'(bus.rsp_data), 64'd0);
    @(posedge ap_clk);
    #1;
    chk("rst_valid_edge", 64'(bus.rsp_valid), 64'd0);
    ap_rst  = 1'b0;
    v       = '0;
    drive();
    m_valid = 1'b0;
    m_id    = 0;
    m_data  = '0;
    m_last  = N - 1;
  endtask

  initial begin
    int g;
    logic [DW-1:0] held;

    tbl[0] = '{0,      16'sd3,     -16'sd4, 4'b0001, 32'hFFFF_FFF4};
    tbl[1] = '{1, 16'sh8000, 16'sh8000, 4'b0010, 32'h4000_0000};
    tbl[2] = '{2, 16'sh8000, 16'sh7fff, 4'b0100, 32'hC000_8000};
    tbl[3] = '{3, 16'sh7fff, 16'sh7fff, 4'b1000, 32'h3FFF_0001};
    tbl[0+4] = '{0,   -16'sd1,   -16'sd1, 4'b0001, 32'h0000_0001};
    tbl[5] = '{3,    16'sd100,  -16'sd200, 4'b1000, 32'hFFFF_B1E0};
    tbl[6] = '{2, 16'sh7fff,   -16'sd1, 4'b0100, 32'hFFFF_8001};
    tbl[7] = '{1,      16'sd0, 16'sh8000, 4'b0010, 32'h0000_0000};

    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    v  = '0;
    rr = 1'b1;
    drive();
    #1;
    do_reset();

    // Table vectors: single requester, known products, one per cycle
    for (int r = 0; r < 8; r++) begin
      v = '0;
      v[tbl[r].id] = 1'b1;
      op_a[tbl[r].id] = tbl[r].a;
      op_b[tbl[r].id] = tbl[r].b;
      drive();
      step(g);
      chk("tbl_ready", 64'(s_ready), 64'(tbl[r].exp_ready));
      chk("tbl_valid", 64'(bus.rsp_valid), 64'd1);
      chk("tbl_id", 64'(bus.rsp_id), 64'(tbl[r].id));
      chk("tbl_data", 64'(bus.rsp_data), 64'(tbl[r].exp_p));
    end
    v = '0;
    drive();
    step(g);
    chk("drain_valid", 64'(bus.rsp_valid), 64'd0);

    // All requesters valid: strict rotation from requester 0
    do_reset();
    v = '1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rnd_op();
      op_b[i] = rnd_op();
    end
    drive();
    for (int k = 0; k < 8; k++) begin
      step(g);
      chk("rr_grant", 64'(g), 64'(k % N));
      op_a[k % N] = rnd_op();
      op_b[k % N] = rnd_op();
      drive();
    end

    // Stall with requesters 1 and 2 pending
    held = bus.rsp_data;
    v    = 4'b0110;
    rr   = 1'b0;
    drive();
    for (int k = 0; k < 5; k++) begin
      step(g);
      chk("stall_ready", 64'(s_ready), 64'd0);
      chk("stall_hold", 64'(bus.rsp_data), 64'(held));
      chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
    end
    rr = 1'b1;
    drive();
    step(g);
    chk("resume_grant", 64'(g), 64'd1);

    // Asynchronous reset between edges while a product is held
    v = '1;
    drive();
    chk("pre_async_valid", 64'(bus.rsp_valid), 64'd1);
    #1;
    ap_rst = 1'b1;
    #1;
    chk("async_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_data", 64'(bus.rsp_data), 64'd0);
    chk("async_ready", 64'(bus.req_ready), 64'd0);
    ap_rst  = 1'b0;
    m_valid = 1'b0;
    m_id    = 0;
    m_data  = '0;
    m_last  = N - 1;
    step(g);
    chk("post_rst_grant", 64'(g), 64'd0);

    // Lone persistent requester 2: ten products, no bubbles
    v = 4'b0100;
    drive();
    for (int k = 0; k < 10; k++) begin
      op_a[2] = rnd_op();
      op_b[2] = rnd_op();
      drive();
      step(g);
      chk("solo_grant", 64'(g), 64'd2);
      chk("solo_valid", 64'(bus.rsp_valid), 64'd1);
      chk("solo_id", 64'(bus.rsp_id), 64'd2);
    end
    v = '0;
    drive();
    step(g);

    // Random traffic: requests hold until accepted, random back-pressure
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom_range(0, 2) == 0)) begin
          v[i]    = 1'b1;
          op_a[i] = rnd_op();
          op_b[i] = rnd_op();
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      drive();
      step(g);
      if (g >= 0) v[g] = 1'b0;
    end
    v  = '0;
    rr = 1'b1;
    drive();
    step(g);
    step(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspline_mul_arbiter.md
QSPLINE_MUL_ARBITER -- requirements
Module: qspline_mul_arbiter

Interface
REQ-001 The block SHALL expose parameter NUM_REQ, default 4, as the number of requesters sharing one multiplier (range 2..8).
REQ-002 The block SHALL expose parameter DIN_W, default 16, as the signed operand width.
REQ-003 The block SHALL expose parameter DOUT_W, default 32, as the signed product width, equal to 2*DIN_W.
REQ-004 ap_clk  in  1  single clock; all state updates on rising edge.
REQ-005 ap_rst  in  1  reset, asynchronous and active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester operand-pair valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a  in  NUM_REQ*DIN_W  flattened signed operand A; slice i belongs to requester i.
REQ-009 req_b  in  NUM_REQ*DIN_W  flattened signed operand B; slice i belongs to requester i.
REQ-010 rsp_valid  out  1  result register holds a product.
REQ-011 rsp_ready  in  1  consumer accepts the result.
REQ-012 rsp_id  out  clog2(NUM_REQ)  index of the requester that owns rsp_data.
REQ-013 rsp_data  out  DOUT_W  signed product.

Function
REQ-014 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 Requesters SHALL hold req_valid, req_a and req_b stable until accepted; the block SHALL NOT sample unaccepted slices.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ and grants the first requester with valid high.
REQ-017 last_grant SHALL update only on an accepted transfer; with no transfer it SHALL hold.
REQ-018 req_ready SHALL be asserted combinationally to the winner only when the result register can accept, i.e. rsp_valid low or rsp_ready high (slot free).
REQ-019 An accepted pair SHALL be multiplied as signed DIN_W x DIN_W -> DOUT_W, full precision, no rounding or saturation.
REQ-020 Latency SHALL be 1 cycle: product, id and rsp_valid appear in the register on the edge following acceptance.
REQ-021 With rsp_ready held high, throughput SHALL be one product per cycle.
REQ-022 When rsp_valid is high and rsp_ready is low, rsp_valid, rsp_id and rsp_data SHALL hold, and all req_ready SHALL be low.
REQ-023 When rsp_ready is high and no request is accepted in the same cycle, rsp_valid SHALL fall on the next edge.
REQ-024 Simultaneous pop (rsp_ready) and push (acceptance) SHALL replace the register contents with the new product, rsp_valid staying high.
REQ-025 The search pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-026 A single persistent requester SHALL be granted every cycle the slot is free; no idle cycles are inserted.
REQ-027 Extreme operands SHALL be exact: (-32768)*(-32768) = 0x4000_0000; (-32768)*32767 = 0xC000_8000.

Reset
REQ-028 ap_rst high SHALL immediately force rsp_valid=0, rsp_id=0, rsp_data=0, last_grant=NUM_REQ-1 (so requester 0 wins first), and all req_ready low.
REQ-029 A result held in the register when reset asserts SHALL be discarded; no transfer SHALL be reported during reset.
REQ-030 After ap_rst deasserts, the first grant SHALL be possible on the first rising edge.

Structure
REQ-031 DIN_W, DOUT_W, default NUM_REQ and the id-width function SHALL live in a shared package qspline_mul_pkg.
REQ-032 The multiply SHALL be one combinational sub-module qspline_mul_core (signed a, b -> p), mapped to a single DSP; the arbiter owns the output register.
REQ-033 The round-robin winner logic SHALL be a combinational function of req_valid and last_grant only.

Verification
REQ-034 After reset, only req 0 valid with a=3, b=-4 -> req_ready[0] same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0xFFFF_FFF4.
REQ-035 All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches, with 1-cycle lag.
REQ-036 Result pending, rsp_ready=0 for 5 cycles with reqs 1,2 valid -> req_ready all low; rsp_data stable; after release, grants resume at the next round-robin winner.
REQ-037 Operands -32768*-32768 and -32768*32767 -> rsp_data 0x4000_0000 and 0xC000_8000.
REQ-038 ap_rst pulsed asynchronously mid-stream, between edges -> rsp_valid drops without an edge, the held product is lost, and the first post-reset grant goes to requester 0.
REQ-039 Only req 2 valid for 10 cycles -> 10 back-to-back products with rsp_id=2 and no bubbles.
